// File: rtl/cmos_capture_pipe.sv
// Pixel-capture engine for parallel CMOS sensors (OV7670 class).
// Synchronises the raw sensor pins into clk and assembles multi-beat pixels.
// Applies a crop window and power-of-two decimation, then presents kept
// pixels on a single-entry valid/ready output register with sof/eol markers.
module cmos_capture_pipe #(
   parameter int DATA_W        = 8,
   parameter int BYTES_PER_PIX = 2,
   parameter int X_BITS        = 11,
   parameter int Y_BITS        = 10,
   parameter int SYNC_STAGES   = 2,
   parameter int VSYNC_POL     = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enable,
   input  logic [X_BITS-1:0]               crop_x0,
   input  logic [X_BITS-1:0]               crop_x1,
   input  logic [Y_BITS-1:0]               crop_y0,
   input  logic [Y_BITS-1:0]               crop_y1,
   input  logic [1:0]                      decim_x,
   input  logic [1:0]                      decim_y,
   input  logic                            cmos_pclk,
   input  logic                            cmos_href,
   input  logic                            cmos_vsync,
   input  logic [DATA_W-1:0]               cmos_db,
   output logic [DATA_W*BYTES_PER_PIX-1:0] pix_data,
   output logic                            pix_valid,
   input  logic                            pix_ready,
   output logic                            pix_sof,
   output logic                            pix_eol,
   output logic                            overflow,
   input  logic                            overflow_clr,
   output logic [15:0]                     frame_count,
   output logic                            busy
);

   localparam int PIX_W = DATA_W * BYTES_PER_PIX;
   localparam logic [1:0] LAST_BEAT = 2'(BYTES_PER_PIX - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   // Synchroniser chains; data travels alongside pclk so both arrive aligned
   logic [SYNC_STAGES-1:0]             pclk_sync_q, href_sync_q, vsync_sync_q;
   logic [SYNC_STAGES-1:0][DATA_W-1:0] db_sync_q;
   logic                               pclk_prev_q, href_prev_q, vact_prev_q;

   state_t              state_q, state_d;
   logic [X_BITS-1:0]   x_q, x_d;
   logic [Y_BITS-1:0]   y_q, y_d;
   logic [1:0]          beat_q, beat_d;
   logic [PIX_W-1:0]    part_q, part_d;
   logic                sof_pend_q, sof_pend_d;
   logic [PIX_W-1:0]    pix_data_q, pix_data_d;
   logic                pix_valid_q, pix_valid_d;
   logic                pix_sof_q, pix_sof_d;
   logic                pix_eol_q, pix_eol_d;
   logic                overflow_q, overflow_d;
   logic [15:0]         frame_count_q, frame_count_d;

   logic                pclk_s, href_s, vact_s;
   logic [DATA_W-1:0]   db_s;
   logic                byte_strobe, href_rise, href_fall, fs, fe;
   logic                capture, complete, keep, load, drop, hs;
   logic [1:0]          beat_eff;
   logic [X_BITS-1:0]   x_eff, x_step, x_off;
   logic [Y_BITS-1:0]   y_step, y_off;
   logic                in_x, in_y, dec_x_ok, dec_y_ok, eol_calc;
   logic [PIX_W-1:0]    pix_asm;

   // Shift raw sensor pins through the synchroniser and keep last-stage history
   always_ff @(posedge clk) begin
      if (rst) begin
         pclk_sync_q  <= '0;
         href_sync_q  <= '0;
         vsync_sync_q <= '0;
         db_sync_q    <= '0;
         pclk_prev_q  <= 1'b0;
         href_prev_q  <= 1'b0;
         vact_prev_q  <= 1'b0;
      end else begin
         pclk_sync_q  <= {pclk_sync_q[SYNC_STAGES-2:0], cmos_pclk};
         href_sync_q  <= {href_sync_q[SYNC_STAGES-2:0], cmos_href};
         vsync_sync_q <= {vsync_sync_q[SYNC_STAGES-2:0], cmos_vsync};
         db_sync_q    <= {db_sync_q[SYNC_STAGES-2:0], cmos_db};
         pclk_prev_q  <= pclk_s;
         href_prev_q  <= href_s;
         vact_prev_q  <= vact_s;
      end
   end

   assign pclk_s      = pclk_sync_q[SYNC_STAGES-1];
   assign href_s      = href_sync_q[SYNC_STAGES-1];
   assign db_s        = db_sync_q[SYNC_STAGES-1];
   // vact_s is high while the sensor is in vertical blanking
   assign vact_s      = (VSYNC_POL != 0) ? vsync_sync_q[SYNC_STAGES-1] : ~vsync_sync_q[SYNC_STAGES-1];
   assign byte_strobe = pclk_s & ~pclk_prev_q & href_s;
   assign href_rise   = href_s & ~href_prev_q;
   assign href_fall   = ~href_s & href_prev_q;
   assign fs          = vact_prev_q & ~vact_s;
   assign fe          = ~vact_prev_q & vact_s;

   // A line start coinciding with a strobe must see cleared counters
   assign beat_eff = href_rise ? 2'd0 : beat_q;
   assign x_eff    = href_rise ? '0 : x_q;

   assign capture  = (state_q == ACTIVE) & byte_strobe;
   assign complete = capture & (beat_eff == LAST_BEAT);

   // Crop window and decimation phase relative to the window origin
   assign x_step   = X_BITS'(1) << decim_x;
   assign y_step   = Y_BITS'(1) << decim_y;
   assign x_off    = x_eff - crop_x0;
   assign y_off    = y_q - crop_y0;
   assign in_x     = (x_eff >= crop_x0) && (x_eff <= crop_x1);
   assign in_y     = (y_q >= crop_y0) && (y_q <= crop_y1);
   assign dec_x_ok = (x_off & (x_step - X_BITS'(1))) == '0;
   assign dec_y_ok = (y_off & (y_step - Y_BITS'(1))) == '0;
   assign keep     = complete & in_x & in_y & dec_x_ok & dec_y_ok;
   assign eol_calc = ({1'b0, x_eff} + {1'b0, x_step}) > {1'b0, crop_x1};

   // Output register either accepts a new pixel or the pixel is lost
   assign hs   = pix_valid_q & pix_ready;
   assign load = keep & (~pix_valid_q | hs);
   assign drop = keep & pix_valid_q & ~hs;

   // Drop the current beat into its slot; first beat lands most-significant
   always_comb begin
      pix_asm = part_q;
      for (int s = 0; s < BYTES_PER_PIX; s++) begin
         if (beat_eff == 2'(BYTES_PER_PIX - 1 - s)) begin
            pix_asm[s*DATA_W +: DATA_W] = db_s;
         end
      end
   end

   // Frame FSM, line/pixel counters, output register and status next-state
   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      beat_d        = beat_q;
      part_d        = part_q;
      sof_pend_d    = sof_pend_q;
      pix_data_d    = pix_data_q;
      pix_valid_d   = pix_valid_q;
      pix_sof_d     = pix_sof_q;
      pix_eol_d     = pix_eol_q;
      overflow_d    = overflow_q;
      frame_count_d = frame_count_q;
      case (state_q)
         IDLE: begin
            if (fs && enable) begin
               state_d    = ACTIVE;
               x_d        = '0;
               y_d        = '0;
               beat_d     = 2'd0;
               sof_pend_d = 1'b1;
            end
         end
         ACTIVE: begin
            if (href_rise) begin
               x_d    = '0;
               beat_d = 2'd0;
            end
            if (href_fall) begin
               y_d = y_q + Y_BITS'(1);
            end
            if (capture) begin
               part_d = pix_asm;
               if (beat_eff == LAST_BEAT) begin
                  beat_d = 2'd0;
                  x_d    = x_eff + X_BITS'(1);
               end else begin
                  beat_d = beat_eff + 2'd1;
               end
            end
            if (fe) begin
               state_d       = IDLE;
               frame_count_d = frame_count_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         pix_data_d  = pix_asm;
         pix_sof_d   = sof_pend_q;
         pix_eol_d   = eol_calc;
         pix_valid_d = 1'b1;
      end else if (hs) begin
         pix_valid_d = 1'b0;
      end
      if (load || drop) begin
         sof_pend_d = 1'b0;
      end
      if (drop) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         x_q           <= '0;
         y_q           <= '0;
         beat_q        <= 2'd0;
         part_q        <= '0;
         sof_pend_q    <= 1'b0;
         pix_data_q    <= '0;
         pix_valid_q   <= 1'b0;
         pix_sof_q     <= 1'b0;
         pix_eol_q     <= 1'b0;
         overflow_q    <= 1'b0;
         frame_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         beat_q        <= beat_d;
         part_q        <= part_d;
         sof_pend_q    <= sof_pend_d;
         pix_data_q    <= pix_data_d;
         pix_valid_q   <= pix_valid_d;
         pix_sof_q     <= pix_sof_d;
         pix_eol_q     <= pix_eol_d;
         overflow_q    <= overflow_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign pix_data    = pix_data_q;
   assign pix_valid   = pix_valid_q;
   assign pix_sof     = pix_sof_q;
   assign pix_eol     = pix_eol_q;
   assign overflow    = overflow_q;
   assign frame_count = frame_count_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: doc/cmos_capture_pipe.md
Name: cmos_capture_pipe

Overview:
Parametrised pixel-capture engine for OV7670-class parallel CMOS sensors, succeeding the fixed RGB565 byte1/byte2 capture path. It samples pclk/href/vsync/db in the system clock domain and assembles BYTES_PER_PIX bytes per pixel. It also applies a runtime crop window and power-of-two decimation, then presents pixels on a valid/ready stream with frame/line markers. It sits between the sensor pins and the pixel FIFO; SCCB register setup is handled elsewhere.

Parameters:
DATA_W, 8, sensor data bus width
BYTES_PER_PIX, 2, sensor beats per pixel (1..4); first beat lands in the MS slot
X_BITS, 11, width of pixel-column counter and crop x bounds
Y_BITS, 10, width of line counter and crop y bounds
SYNC_STAGES, 2, synchroniser depth (>=2) applied identically to pclk, href, vsync, db
VSYNC_POL, 1, 1 = vsync high during blanking (frame starts on falling edge); 0 = inverted

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  capture enable, sampled only at frame start
crop_x0, crop_x1  in  X_BITS  inclusive first/last kept column (pixel units)
crop_y0, crop_y1  in  Y_BITS  inclusive first/last kept line
decim_x, decim_y  in  2  keep every 2^n-th column/line, n = 0..3
cmos_pclk, cmos_href, cmos_vsync  in  1  raw sensor timing
cmos_db  in  DATA_W  raw sensor data
pix_data  out  DATA_W*BYTES_PER_PIX  assembled pixel
pix_valid  out  1  pixel available
pix_ready  in  1  downstream accepts when valid && ready
pix_sof  out  1  qualifies pix_data: first kept pixel of frame
pix_eol  out  1  qualifies pix_data: last kept pixel of line
overflow  out  1  sticky: a pixel was dropped
overflow_clr  in  1  clears overflow (loses to a same-cycle new drop)
frame_count  out  16  completed captured frames, wraps
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchronisers cleared. rst mid-frame discards any partial pixel and held pixel.
- All four sensor inputs pass through SYNC_STAGES flops. byte_strobe = synced pclk rising edge (last stage 1, previous 0) while synced href = 1. db is taken from the same stage as pclk.
- Frame start (fs) = synced vsync active-to-inactive transition, per VSYNC_POL. Frame end (fe) = inactive-to-active transition.
- FSM:
  - IDLE: on fs with enable=1 -> ACTIVE. x, y and beat counters are cleared and sof_pending is set. fs with enable=0 stays in IDLE.
  - ACTIVE: capture. On fe -> IDLE, frame_count+1. Deasserting enable mid-frame has no effect until fe.
- Line handling: synced href rising edge clears x and the beat counter. Synced href falling edge increments y. A partial pixel at href fall is discarded silently and is not counted as overflow.
- Assembly: beat k (0-based) written to pix slot [BYTES_PER_PIX-1-k]. The final beat completes the pixel; x then increments by 1 and wraps at 2^X_BITS.
- Keep test, evaluated on the completing beat:
  - crop_x0 <= x <= crop_x1 and crop_y0 <= y <= crop_y1
  - (x-crop_x0) mod 2^decim_x = 0 and (y-crop_y0) mod 2^decim_y = 0
  - crop_x0 > crop_x1 or crop_y0 > crop_y1 keeps nothing.
- eol for a kept pixel = (x + 2^decim_x > crop_x1). sof = sof_pending; sof_pending clears when that pixel is loaded or dropped.
- Output register, single entry:
  - A kept pixel loads pix_data/sof/eol and sets pix_valid on the next cycle after the completing strobe (latency 1 clk after strobe detection).
  - pix_valid holds, with data stable, until valid && ready. It then drops the following cycle unless a new kept pixel loads that same cycle, which gives back-to-back valid.
  - If a kept pixel completes while the register is occupied and not handshaking that cycle, the new pixel is dropped, the held pixel is kept, and overflow sets.
- Held pixel at fe remains valid until accepted.
- Pixel rate constraint: pclk <= clk/4. A faster pclk is out of contract.

Test Plan:
- BPP=2, crop 0..3 x 0..1, decim 0, ready=1, 4x2 frame of bytes 0x01..0x10: 8 pixels 0x0102..0x0F10. sof on the first pixel, eol on pixels 4 and 8, frame_count=1, overflow=0.
- 8x4 frame with crop x 2..7, y 1..3, decim_x=1, decim_y=1: kept (x,y) = (2,1),(4,1),(6,1),(2,3),(4,3),(6,3). eol at x=6.
- pix_ready held 0 for a whole 4-pixel line: first pixel held stable, 3 dropped, overflow=1. overflow_clr pulse -> 0. A simultaneous clr and new drop -> stays 1.
- enable=0 at fs: no pix_valid for the frame, frame_count unchanged. Enable dropped mid-frame: the frame completes and frame_count increments.
- href falls after 3 beats with BPP=2: the third beat is discarded, the next line starts at the MS slot, and overflow stays 0.
- rst asserted mid-line with pix_valid=1: the next cycle gives valid=0, busy=0 and frame_count=0. Capture resumes only after the next fs.
